// File: rtl/uart_rx_ly1.sv
// uart_rx_ly1: 8N1 UART receiver with 2-flop input synchroniser, mid-bit
// sampling, a one-entry holding register with available/read handshake,
// one-cycle framing-error pulse and sticky overrun flag.
module uart_rx_ly1 #(
    parameter int CLKS_PER_BIT = 2500,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       line_rx,
    input  logic       rd_en,
    output logic [7:0] rx_data,
    output logic       rx_avail,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            commit_q, commit_d;
    logic            ferr_q, ferr_d;
    logic [7:0]      data_q, data_d;
    logic            avail_q, avail_d;
    logic            ovr_q, ovr_d;
    logic            s1_q, s2_q, s3_q;
    logic            start_edge;

    // s1/s2 resynchronise the asynchronous line; s3 delays s2 for falling-edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= line_rx;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign start_edge = s3_q & ~s2_q;

    // Receiver FSM and its datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            commit_q <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            commit_q <= commit_d;
            ferr_q   <= ferr_d;
        end
    end

    // Next-state logic: the baud counter restarts on every state change and on each data-bit boundary
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        commit_d = 1'b0;
        ferr_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start_edge) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!s2_q) begin
                        state_d = S_DATA;
                        bit_d   = '0;
                    end else begin
                        // line went high again before mid start bit: a glitch
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {s2_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == BIT_LAST) begin
                    cnt_d    = '0;
                    commit_d = s2_q;
                    ferr_d   = ~s2_q;
                    state_d  = s2_q ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                // line must return high before another start edge is honoured
                if (s2_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Holding register: a commit overrides a read; overrun only tracks unread overwrites
    always_comb begin
        data_d  = data_q;
        avail_d = avail_q;
        ovr_d   = ovr_q;
        if (commit_q) begin
            data_d  = shift_q;
            avail_d = 1'b1;
            if (avail_q && !rd_en) begin
                ovr_d = 1'b1;
            end
        end else if (rd_en && avail_q) begin
            avail_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    // Holding register and status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= 8'h00;
            avail_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            avail_q <= avail_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_avail  = avail_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_ly1.sv
// tb_uart_rx_ly1: directed bench for uart_rx_ly1 with a short bit time.
module tb_uart_rx_ly1;

    localparam int C = 16;
    localparam int H = C / 2;
    localparam int LAT = 4 + H + 9 * C;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       line_rx;
    logic       rd_en;
    logic [7:0] rx_data;
    logic       rx_avail;
    logic       frame_err;
    logic       overrun;

    uart_rx_ly1 #(.CLKS_PER_BIT(C), .HALF_BIT(H)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .line_rx  (line_rx),
        .rd_en    (rd_en),
        .rx_data  (rx_data),
        .rx_avail (rx_avail),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int ferr_cnt = 0;
    logic ferr_prev = 1'b0;
    logic ferr_wide = 1'b0;
    logic avail_prev = 1'b0;
    int rise_cyc = 0;
    int start_cyc = 0;
    int total = 0;
    int bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // frame_err pulse counting and width tracking, rx_avail rise time
    always @(negedge clk) begin
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (frame_err && ferr_prev) ferr_wide <= 1'b1;
        ferr_prev <= frame_err;
        if (rx_avail && !avail_prev) rise_cyc <= cyc;
        avail_prev <= rx_avail;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       rd_after;
        logic       exp_avail;
        logic [7:0] exp_data;
        logic       exp_ovr;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        line_rx = v;
        repeat (C) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic read_pulse();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    // send a frame and assert rd_en exactly on the edge that commits it
    task automatic send_read_on_commit(input logic [7:0] d);
        fork
            send_frame(d, 1'b1);
            begin
                automatic int tgt = cyc + LAT - 1;
                automatic int n = 0;
                do begin
                    tick();
                    n++;
                end while (cyc != tgt && n < 1000);
                rd_en = 1'b1;
                tick();
                rd_en = 1'b0;
            end
        join
        repeat (4) tick();
    endtask

    initial begin
        int f0;
        vecs[0] = '{8'h47, 1'b1, 1'b1, 1'b1, 8'h47, 1'b0, 0};
        vecs[1] = '{8'h31, 1'b1, 1'b1, 1'b1, 8'h31, 1'b0, 0};
        vecs[2] = '{8'h47, 1'b0, 1'b0, 1'b0, 8'h31, 1'b0, 1};
        vecs[3] = '{8'h31, 1'b1, 1'b1, 1'b1, 8'h31, 1'b0, 0};
        vecs[4] = '{8'h47, 1'b1, 1'b0, 1'b1, 8'h47, 1'b0, 0};
        vecs[5] = '{8'h31, 1'b1, 1'b1, 1'b1, 8'h31, 1'b1, 0};
        vecs[6] = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 0};
        vecs[7] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 0};
        vecs[8] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 0};

        rst_n = 1'b0;
        line_rx = 1'b1;
        rd_en = 1'b0;
        repeat (5) tick();
        check("reset rx_data", rx_data, 8'h00);
        check("reset rx_avail", rx_avail, 1'b0);
        check("reset frame_err", frame_err, 1'b0);
        check("reset overrun", overrun, 1'b0);
        rst_n = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < 9; i++) begin
            f0 = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].stop);
            if (!vecs[i].stop) begin
                line_rx = 1'b0;
                repeat (20) tick();
                line_rx = 1'b1;
                repeat (C) tick();
            end
            repeat (4) tick();
            check($sformatf("vec%0d rx_avail", i), rx_avail, vecs[i].exp_avail);
            check($sformatf("vec%0d rx_data", i), rx_data, vecs[i].exp_data);
            check($sformatf("vec%0d overrun", i), overrun, vecs[i].exp_ovr);
            check($sformatf("vec%0d frame_err pulses", i), ferr_cnt - f0, vecs[i].exp_ferr);
            if (i == 0) begin
                check("latency in window",
                      ((rise_cyc - start_cyc) >= LAT - 1) && ((rise_cyc - start_cyc) <= LAT + 1), 1'b1);
            end
            if (vecs[i].rd_after) begin
                read_pulse();
                check($sformatf("vec%0d avail after read", i), rx_avail, 1'b0);
                check($sformatf("vec%0d overrun after read", i), overrun, 1'b0);
            end
        end

        // read while empty is ignored
        read_pulse();
        tick();
        check("empty read avail", rx_avail, 1'b0);
        check("empty read overrun", overrun, 1'b0);

        // short low glitch must not start a frame
        f0 = ferr_cnt;
        line_rx = 1'b0;
        repeat (4) tick();
        line_rx = 1'b1;
        repeat (2 * C) tick();
        check("glitch avail", rx_avail, 1'b0);
        check("glitch overrun", overrun, 1'b0);
        check("glitch frame_err", ferr_cnt - f0, 0);
        send_frame(8'h47, 1'b1);
        repeat (4) tick();
        check("post-glitch avail", rx_avail, 1'b1);
        check("post-glitch data", rx_data, 8'h47);
        read_pulse();

        // read coinciding with commit: byte stored, overrun unchanged
        send_frame(8'h47, 1'b1);
        repeat (4) tick();
        send_read_on_commit(8'h31);
        check("simul rd avail", rx_avail, 1'b1);
        check("simul rd data", rx_data, 8'h31);
        check("simul rd overrun stays 0", overrun, 1'b0);
        send_frame(8'h5A, 1'b1);
        repeat (4) tick();
        check("overrun set", overrun, 1'b1);
        check("overrun data", rx_data, 8'h5A);
        send_read_on_commit(8'hC3);
        check("simul rd avail 2", rx_avail, 1'b1);
        check("simul rd data 2", rx_data, 8'hC3);
        check("simul rd overrun stays 1", overrun, 1'b1);
        read_pulse();
        check("final read avail", rx_avail, 1'b0);
        check("final read overrun", overrun, 1'b0);

        // reset during data bit 4 with a full, overrun holding register
        send_frame(8'h47, 1'b1);
        send_frame(8'h31, 1'b1);
        repeat (4) tick();
        check("pre-reset overrun", overrun, 1'b1);
        f0 = ferr_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(vecs[0].data[i]);
        line_rx = vecs[0].data[4];
        repeat (H) tick();
        rst_n = 1'b0;
        repeat (5) tick();
        line_rx = 1'b1;
        check("midreset rx_data", rx_data, 8'h00);
        check("midreset rx_avail", rx_avail, 1'b0);
        check("midreset frame_err", frame_err, 1'b0);
        check("midreset overrun", overrun, 1'b0);
        rst_n = 1'b1;
        repeat (12 * C) tick();
        check("post-reset no avail", rx_avail, 1'b0);
        check("post-reset no frame_err", ferr_cnt - f0, 0);
        send_frame(8'h47, 1'b1);
        repeat (4) tick();
        check("post-reset avail", rx_avail, 1'b1);
        check("post-reset data", rx_data, 8'h47);
        check("post-reset overrun", overrun, 1'b0);

        check("frame_err one cycle wide", ferr_wide, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
